// File: rtl/small_fifo_sync.sv
// Shallow synchronous FIFO with registered read data and occupancy-derived
// status flags (empty, full, nearly_full, prog_full).
module small_fifo_sync #(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);

  localparam int DEPTH = 2**MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] NF_C    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESHOLD);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wptr;
  logic [MAX_DEPTH_BITS-1:0] rptr;
  logic [CW-1:0]             count;
  logic                      wr_ok;
  logic                      rd_ok;

  always_comb begin
    empty       = (count == '0);
    full        = (count == DEPTH_C);
    nearly_full = (count >= NF_C);
    prog_full   = (count >= PF_C);
    wr_ok       = wr_en && !full;
    rd_ok       = rd_en && !empty;
  end

  // Storage is not reset; clearing the pointers and count is enough to discard it.
  always_ff @(posedge clk) begin
    if (reset && wr_ok)
      mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_ok)
        wptr <= wptr + 1'b1;
      if (rd_ok) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && wr_en && full)
      $warning("%m: write while full, word dropped");
    if (reset && rd_en && empty)
      $warning("%m: read while empty, ignored");
  end
`endif

endmodule

// File: tb/tb_small_fifo_sync.sv
// Directed and randomised-stream checks for small_fifo_sync at depth 4.
module tb_small_fifo_sync;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] dout;
  logic         full;
  logic         nearly_full;
  logic         prog_full;
  logic         empty;

  int n_checks = 0;
  int n_fail   = 0;

  small_fifo_sync #(
    .WIDTH               (W),
    .MAX_DEPTH_BITS      (2),
    .PROG_FULL_THRESHOLD (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .full        (full),
    .nearly_full (nearly_full),
    .prog_full   (prog_full),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flags packed as {empty, nearly_full, prog_full, full}.
  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, 32'({empty, nearly_full, prog_full, full}), 32'(exp));
  endtask

  // One clock with the given inputs; returns #1 after the edge.
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  logic [W-1:0] q[$];
  logic [W-1:0] exp_d;
  int           cnt;
  int           n_wr;
  int           n_rd;
  int           guard;
  logic         w;
  logic         r;
  logic         rd_ok;

  initial begin
    reset = 1'b0;
    din   = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;

    // Reset held for two clocks
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_flags("reset_flags", 4'b1000);
    check("reset_dout", 32'(dout), 32'h0);

    // Fill to full, then overflow attempt
    cyc(1'b1, 16'h000A, 1'b0);
    check_flags("fill1", 4'b0000);
    cyc(1'b1, 16'h000B, 1'b0);
    check_flags("fill2", 4'b0010);
    cyc(1'b1, 16'h000C, 1'b0);
    check_flags("fill3_nearly_full", 4'b0110);
    cyc(1'b1, 16'h000D, 1'b0);
    check_flags("fill4_full", 4'b0111);
    cyc(1'b1, 16'h000E, 1'b0);
    check_flags("overflow_flags", 4'b0111);
    check("overflow_dout", 32'(dout), 32'h0);

    // Drain: E must never appear
    cyc(1'b0, '0, 1'b1);
    check("pop_a", 32'(dout), 32'h000A);
    check_flags("pop_a_flags", 4'b0110);
    cyc(1'b0, '0, 1'b1);
    check("pop_b", 32'(dout), 32'h000B);
    check_flags("pop_b_flags", 4'b0010);
    cyc(1'b0, '0, 1'b1);
    check("pop_c", 32'(dout), 32'h000C);
    check_flags("pop_c_flags", 4'b0000);
    cyc(1'b0, '0, 1'b1);
    check("pop_d", 32'(dout), 32'h000D);
    check_flags("pop_d_empty", 4'b1000);

    // Underflow attempt
    cyc(1'b0, '0, 1'b1);
    check("underflow_dout", 32'(dout), 32'h000D);
    check_flags("underflow_flags", 4'b1000);

    // Write and read into empty FIFO: no bypass
    cyc(1'b1, 16'h0055, 1'b1);
    check("nobypass_dout", 32'(dout), 32'h000D);
    check_flags("nobypass_flags", 4'b0000);
    cyc(1'b0, '0, 1'b1);
    check("nobypass_pop", 32'(dout), 32'h0055);
    check_flags("nobypass_empty", 4'b1000);

    // Simultaneous write and read at occupancy 2
    cyc(1'b1, 16'h0001, 1'b0);
    cyc(1'b1, 16'h0002, 1'b0);
    cyc(1'b1, 16'h0003, 1'b1);
    check("simul_dout", 32'(dout), 32'h0001);
    check_flags("simul_count2", 4'b0010);
    cyc(1'b0, '0, 1'b1);
    check("simul_pop2", 32'(dout), 32'h0002);
    cyc(1'b0, '0, 1'b1);
    check("simul_pop3", 32'(dout), 32'h0003);
    check_flags("simul_empty", 4'b1000);

    // Random stream across pointer wraps against a queue model
    q     = {};
    cnt   = 0;
    n_wr  = 0;
    n_rd  = 0;
    guard = 0;
    while (n_rd < 20 && guard < 500) begin
      w     = (n_wr < 20) && (cnt < 3) && ($urandom_range(0, 3) != 0);
      r     = ($urandom_range(0, 1) == 1);
      rd_ok = r && (cnt > 0);
      exp_d = '0;
      if (rd_ok) begin
        exp_d = q.pop_front();
        cnt--;
        n_rd++;
      end
      cyc(w, W'(16'h0100 + n_wr), r);
      if (w) begin
        q.push_back(W'(16'h0100 + n_wr));
        cnt++;
        n_wr++;
      end
      if (rd_ok)
        check("stream_dout", 32'(dout), 32'(exp_d));
      check_flags("stream_flags",
                  {cnt == 0, cnt >= 3, cnt >= 2, cnt == 4});
      guard++;
    end
    check("stream_done", 32'(n_rd), 32'd20);

    // Reset with three words stored
    cyc(1'b1, 16'h0061, 1'b0);
    cyc(1'b1, 16'h0062, 1'b0);
    cyc(1'b1, 16'h0063, 1'b0);
    cyc(1'b1, 16'h0064, 1'b0);
    cyc(1'b0, '0, 1'b1);
    check("prereset_dout", 32'(dout), 32'h0061);
    check_flags("prereset_flags", 4'b0110);
    reset = 1'b0;
    cyc(1'b0, '0, 1'b0);
    reset = 1'b1;
    check_flags("midreset_flags", 4'b1000);
    check("midreset_dout", 32'(dout), 32'h0);
    cyc(1'b1, 16'h0077, 1'b0);
    cyc(1'b1, 16'h0088, 1'b0);
    cyc(1'b0, '0, 1'b1);
    check("postreset_pop1", 32'(dout), 32'h0077);
    cyc(1'b0, '0, 1'b1);
    check("postreset_pop2", 32'(dout), 32'h0088);
    check_flags("postreset_empty", 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
